// File: rtl/rx_tuning_scheduler.sv
// Frequency-hop scheduler: steps the complex/real DDS phase increments through a hop table on
// NUMBER_OF_PATH-sample group boundaries. Optional post-retune mute selected by RX_TUNE_HOLDOFF_EN.
module rx_tuning_scheduler #(
  parameter int NUMBER_OF_PATH = 4,
  parameter int TABLE_DEPTH    = 8,
  parameter int DWELL_WIDTH    = 16,
  parameter int HOLDOFF_CYCLES = 32,
  localparam int AW = $clog2(TABLE_DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [AW-1:0]          wr_addr,
  input  logic [15:0]            wr_cinc,
  input  logic [15:0]            wr_rinc,
  input  logic [DWELL_WIDTH-1:0] wr_dwell,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   loop_en,
  input  logic [AW:0]            hop_count,
  output logic [15:0]            complex_phase_inc,
  output logic [15:0]            real_phase_inc,
  output logic                   tune_apply,
  output logic [AW-1:0]          hop_index,
  output logic                   busy,
  output logic                   hop_done,
  output logic                   cfg_err,
  output logic                   rx_mute
);

  localparam int PW = $clog2(NUMBER_OF_PATH);

  // The LOAD cycle must fit inside the final group, so at least two paths are required.
  if (NUMBER_OF_PATH < 2 || HOLDOFF_CYCLES < 1 || TABLE_DEPTH < 2 ||
      (TABLE_DEPTH & (TABLE_DEPTH - 1)) != 0) begin : g_param_check
    $error("rx_tuning_scheduler: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, LOAD, DWELL, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [PW-1:0]          path_cnt_reg;
  logic                   boundary, pre_boundary;
  logic [AW-1:0]          idx_reg, idx_next;
  logic [AW:0]            count_reg;
  logic                   loop_reg;
  logic [DWELL_WIDTH-1:0] group_cnt_reg;
  logic [DWELL_WIDTH-1:0] cur_dwell_reg;
  logic [DWELL_WIDTH-1:0] dwell_last;
  logic                   is_last;
  logic                   start_ok;
  logic                   apply;
  logic                   accept;
  logic                   wr_fire;

  logic [15:0]            cinc_mem  [TABLE_DEPTH];
  logic [15:0]            rinc_mem  [TABLE_DEPTH];
  logic [DWELL_WIDTH-1:0] dwell_mem [TABLE_DEPTH];
  logic [15:0]            rd_cinc_reg, rd_rinc_reg;
  logic [DWELL_WIDTH-1:0] rd_dwell_reg;

  logic [15:0]            cinc_reg, rinc_reg;
  logic [AW-1:0]          hop_index_reg;
  logic                   tune_apply_reg;
  logic                   cfg_err_reg;

  assign boundary     = (path_cnt_reg == PW'(NUMBER_OF_PATH - 1));
  assign pre_boundary = (path_cnt_reg == PW'(NUMBER_OF_PATH - 2));

  always_ff @(posedge clock) begin
    if (reset) begin
      path_cnt_reg <= '0;
    end else if (boundary) begin
      path_cnt_reg <= '0;
    end else begin
      path_cnt_reg <= path_cnt_reg + PW'(1);
    end
  end

  assign busy     = (state_reg != IDLE);
  assign wr_ready = !busy;
  assign wr_fire  = wr_valid && wr_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < TABLE_DEPTH; i++) begin
        cinc_mem[i]  <= '0;
        rinc_mem[i]  <= '0;
        dwell_mem[i] <= '0;
      end
    end else if (wr_fire) begin
      cinc_mem[wr_addr]  <= wr_cinc;
      rinc_mem[wr_addr]  <= wr_rinc;
      dwell_mem[wr_addr] <= wr_dwell;
    end
  end

  // Read address follows the next index so the entry is already registered when LOAD hits its boundary.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_cinc_reg  <= '0;
      rd_rinc_reg  <= '0;
      rd_dwell_reg <= '0;
    end else begin
      rd_cinc_reg  <= cinc_mem[idx_next];
      rd_rinc_reg  <= rinc_mem[idx_next];
      rd_dwell_reg <= dwell_mem[idx_next];
    end
  end

  assign start_ok   = (hop_count != '0) && (hop_count <= (AW + 1)'(TABLE_DEPTH));
  assign is_last    = ({1'b0, idx_reg} == count_reg - (AW + 1)'(1));
  assign dwell_last = (cur_dwell_reg == '0) ? '0 : cur_dwell_reg - DWELL_WIDTH'(1);

  // A continuing hop leaves DWELL one cycle early so LOAD owns the closing boundary cycle
  // and the next apply lands with no gap; a finishing hop stays through the boundary.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    apply      = 1'b0;
    accept     = 1'b0;
    if (stop) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && start_ok) begin
            state_next = LOAD;
            idx_next   = '0;
            accept     = 1'b1;
          end
        end
        LOAD: begin
          if (boundary) begin
            state_next = DWELL;
            apply      = 1'b1;
          end
        end
        DWELL: begin
          if (group_cnt_reg == dwell_last) begin
            if (!is_last || loop_reg) begin
              if (pre_boundary) begin
                state_next = LOAD;
                idx_next   = is_last ? '0 : idx_reg + AW'(1);
              end
            end else if (boundary) begin
              state_next = DONE;
            end
          end
        end
        DONE: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      count_reg      <= '0;
      loop_reg       <= 1'b0;
      group_cnt_reg  <= '0;
      cur_dwell_reg  <= '0;
      cinc_reg       <= '0;
      rinc_reg       <= '0;
      hop_index_reg  <= '0;
      tune_apply_reg <= 1'b0;
      cfg_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      tune_apply_reg <= apply;
      cfg_err_reg    <= !stop && (state_reg == IDLE) && start && !start_ok;
      if (accept) begin
        count_reg <= hop_count;
        loop_reg  <= loop_en;
      end
      if (apply) begin
        cinc_reg      <= rd_cinc_reg;
        rinc_reg      <= rd_rinc_reg;
        hop_index_reg <= idx_reg;
        cur_dwell_reg <= rd_dwell_reg;
        group_cnt_reg <= '0;
      end else if (state_reg == DWELL && boundary) begin
        group_cnt_reg <= group_cnt_reg + DWELL_WIDTH'(1);
      end
    end
  end

  assign complex_phase_inc = cinc_reg;
  assign real_phase_inc    = rinc_reg;
  assign hop_index         = hop_index_reg;
  assign tune_apply        = tune_apply_reg;
  assign cfg_err           = cfg_err_reg;
  assign hop_done          = (state_reg == DONE);

`ifdef RX_TUNE_HOLDOFF_EN
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  logic [HW-1:0] mute_cnt_reg;

  // Loaded on the same edge that raises tune_apply, so the mute window starts with the retune.
  always_ff @(posedge clock) begin
    if (reset) begin
      mute_cnt_reg <= '0;
    end else if (apply) begin
      mute_cnt_reg <= HW'(HOLDOFF_CYCLES);
    end else if (mute_cnt_reg != '0) begin
      mute_cnt_reg <= mute_cnt_reg - HW'(1);
    end
  end

  assign rx_mute = (mute_cnt_reg != '0);
`else
  assign rx_mute = 1'b0;
`endif

endmodule

// File: tb/tb_rx_tuning_scheduler.sv
// Bench for rx_tuning_scheduler: expected tune events are queued at stimulus time and
// compared by a monitor as the DUT applies them; scenario tasks check the rest inline.
module tb_rx_tuning_scheduler;

  localparam int NP = 4;
  localparam int TD = 8;
  localparam int DW = 16;
  localparam int HO = 32;
`ifdef RX_TUNE_HOLDOFF_EN
  localparam logic HOLD = 1'b1;
`else
  localparam logic HOLD = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [2:0]    wr_addr = '0;
  logic [15:0]   wr_cinc = '0;
  logic [15:0]   wr_rinc = '0;
  logic [DW-1:0] wr_dwell = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop_en = 1'b0;
  logic [3:0]    hop_count = '0;
  logic [15:0]   complex_phase_inc;
  logic [15:0]   real_phase_inc;
  logic          tune_apply;
  logic [2:0]    hop_index;
  logic          busy;
  logic          hop_done;
  logic          cfg_err;
  logic          rx_mute;

  rx_tuning_scheduler #(
    .NUMBER_OF_PATH(NP), .TABLE_DEPTH(TD), .DWELL_WIDTH(DW), .HOLDOFF_CYCLES(HO)
  ) dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_cinc(wr_cinc), .wr_rinc(wr_rinc), .wr_dwell(wr_dwell),
    .start(start), .stop(stop), .loop_en(loop_en), .hop_count(hop_count),
    .complex_phase_inc(complex_phase_inc), .real_phase_inc(real_phase_inc),
    .tune_apply(tune_apply), .hop_index(hop_index), .busy(busy),
    .hop_done(hop_done), .cfg_err(cfg_err), .rx_mute(rx_mute)
  );

  always #5 clock = ~clock;

  // cyc numbers clock cycles; ph is the expected path-counter value in that cycle.
  int cyc = 0;
  int ph = 0;
  always @(posedge clock) begin
    cyc = cyc + 1;
    if (reset) ph = 0;
    else ph = (ph + 1) % NP;
  end

  typedef struct {
    logic [15:0] c;
    logic [15:0] r;
    logic [2:0]  idx;
    int          gap;   // cycles since previous apply, -1 = unchecked
    int          at;    // absolute cycle, -1 = unchecked
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];      // expected hop_done distance from the last apply
  int   errors = 0;
  int   checks = 0;
  int   last_apply = 0;
  int   applies = 0;
  int   dones = 0;
  int   mute_cycles = 0;

  always @(negedge clock) begin
    exp_t e;
    if (rx_mute === 1'b1) mute_cycles++;
    if (tune_apply === 1'b1) begin
      applies++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_apply cyc=%0d cinc=%h idx=%0d", cyc, complex_phase_inc, hop_index);
      end else begin
        e = exp_q.pop_front();
        if ({complex_phase_inc, real_phase_inc, hop_index} !== {e.c, e.r, e.idx}) begin
          errors++;
          $display("FAIL apply_values got=%h/%h/%0d exp=%h/%h/%0d", complex_phase_inc, real_phase_inc,
                   hop_index, e.c, e.r, e.idx);
        end
        if (e.gap >= 0) begin
          checks++;
          if (cyc - last_apply !== e.gap) begin
            errors++;
            $display("FAIL apply_spacing got=%0d exp=%0d", cyc - last_apply, e.gap);
          end
        end
        if (e.at >= 0) begin
          checks++;
          if (cyc !== e.at) begin
            errors++;
            $display("FAIL apply_cycle got=%0d exp=%0d", cyc, e.at);
          end
        end
        checks++;
        if (ph !== 0) begin
          errors++;
          $display("FAIL apply_phase got=%0d exp=0", ph);
        end
        checks++;
        if (rx_mute !== HOLD) begin
          errors++;
          $display("FAIL mute_at_apply got=%b exp=%b", rx_mute, HOLD);
        end
      end
      last_apply = cyc;
    end
    if (hop_done === 1'b1) begin
      dones++;
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cyc=%0d", cyc);
      end else if (cyc - last_apply !== done_q[0]) begin
        errors++;
        $display("FAIL done_spacing got=%0d exp=%0d", cyc - last_apply, done_q[0]);
        void'(done_q.pop_front());
      end else begin
        void'(done_q.pop_front());
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic write_entry(input logic [2:0] a, input logic [15:0] c, input logic [15:0] r,
                             input logic [DW-1:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_cinc = c; wr_rinc = r; wr_dwell = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic start_seq(input logic [3:0] cnt, input logic lp);
    start = 1'b1; hop_count = cnt; loop_en = lp;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_timeout busy=%b exp=0", name, busy);
    end
  endtask

  task automatic wait_applies(input int target, input int budget, input string name);
    int n = 0;
    while (applies < target && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (applies < target) begin
      errors++;
      $display("FAIL %s_apply_timeout got=%0d exp=%0d", name, applies, target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
    checks++;
    if ({complex_phase_inc, real_phase_inc} !== 32'h0) begin
      errors++; $display("FAIL reset_incs got=%h/%h exp=0/0", complex_phase_inc, real_phase_inc);
    end
    checks++;
    if ({tune_apply, hop_done, cfg_err, rx_mute} !== 4'b0) begin
      errors++; $display("FAIL reset_pulses got=%b exp=0000", {tune_apply, hop_done, cfg_err, rx_mute});
    end
    checks++;
    if (hop_index !== 3'd0) begin errors++; $display("FAIL reset_index got=%0d exp=0", hop_index); end
  endtask

  task automatic test_single();
    write_entry(3'd0, 16'h1000, 16'h0800, 16'd2);
    write_entry(3'd1, 16'h2000, 16'h0400, 16'd3);
    exp_q.push_back('{16'h1000, 16'h0800, 3'd0, -1, -1});
    exp_q.push_back('{16'h2000, 16'h0400, 3'd1, 8, -1});
    done_q.push_back(12);
    start_seq(4'd2, 1'b0);
    wait_idle(60, "single");
    tick(2);
    checks++;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      errors++; $display("FAIL single_pending got=%0d/%0d exp=0/0", exp_q.size(), done_q.size());
    end
    checks++;
    if ({complex_phase_inc, real_phase_inc, hop_index} !== {16'h2000, 16'h0400, 3'd1}) begin
      errors++; $display("FAIL single_hold got=%h/%h/%0d exp=2000/0400/1", complex_phase_inc,
                         real_phase_inc, hop_index);
    end
  endtask

  task automatic test_alignment();
    for (int p = 0; p < NP; p++) begin
      int n = 0;
      int lat;
      while (ph != p && n < 2 * NP) begin
        tick();
        n++;
      end
      lat = (p == NP - 1) ? NP + 1 : NP - p;
      exp_q.push_back('{16'h1000, 16'h0800, 3'd0, -1, cyc + lat});
      done_q.push_back(8);
      start_seq(4'd1, 1'b0);
      wait_idle(40, "align");
    end
    tick();
    checks++;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      errors++; $display("FAIL align_pending got=%0d/%0d exp=0/0", exp_q.size(), done_q.size());
    end
  endtask

  task automatic test_loop_stop();
    int base_a = applies;
    int base_d = dones;
    exp_q.push_back('{16'h1000, 16'h0800, 3'd0, -1, -1});
    exp_q.push_back('{16'h2000, 16'h0400, 3'd1, 8, -1});
    exp_q.push_back('{16'h1000, 16'h0800, 3'd0, 12, -1});
    exp_q.push_back('{16'h2000, 16'h0400, 3'd1, 8, -1});
    start_seq(4'd2, 1'b1);
    wait_applies(base_a + 4, 100, "loop");
    tick(3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy got=%b exp=0", busy); end
    tick(20);
    checks++;
    if (dones != base_d || applies != base_a + 4) begin
      errors++; $display("FAIL stop_quiet got=%0d/%0d exp=%0d/%0d", dones, applies, base_d, base_a + 4);
    end
    checks++;
    if ({complex_phase_inc, real_phase_inc} !== {16'h2000, 16'h0400}) begin
      errors++; $display("FAIL stop_hold got=%h/%h exp=2000/0400", complex_phase_inc, real_phase_inc);
    end
  endtask

  task automatic test_errors();
    int base_a;
    start_seq(4'd0, 1'b0);
    checks++;
    if ({cfg_err, busy} !== 2'b10) begin
      errors++; $display("FAIL err_zero got=%b exp=10", {cfg_err, busy});
    end
    tick();
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_pulse_width got=%b exp=0", cfg_err); end
    start_seq(4'd9, 1'b0);
    checks++;
    if ({cfg_err, busy} !== 2'b10) begin
      errors++; $display("FAIL err_nine got=%b exp=10", {cfg_err, busy});
    end
    base_a = applies;
    start = 1'b1; stop = 1'b1; hop_count = 4'd1; loop_en = 1'b0;
    tick();
    start = 1'b0; stop = 1'b0;
    checks++;
    if ({busy, cfg_err} !== 2'b00) begin
      errors++; $display("FAIL start_stop got=%b exp=00", {busy, cfg_err});
    end
    tick(8);
    checks++;
    if (applies != base_a) begin errors++; $display("FAIL start_stop_apply got=%0d exp=%0d", applies, base_a); end
    exp_q.push_back('{16'h1000, 16'h0800, 3'd0, -1, -1});
    done_q.push_back(8);
    start_seq(4'd1, 1'b0);
    wr_valid = 1'b1; wr_addr = 3'd0; wr_cinc = 16'hDEAD; wr_rinc = 16'hBEEF; wr_dwell = 16'd5;
    checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL busy_wr_ready got=%b exp=0", wr_ready); end
    tick();
    wr_valid = 1'b0;
    wait_idle(40, "busy_write");
    exp_q.push_back('{16'h1000, 16'h0800, 3'd0, -1, -1});
    done_q.push_back(8);
    start_seq(4'd1, 1'b0);
    wait_idle(40, "recheck");
    tick();
    checks++;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      errors++; $display("FAIL busy_write_pending got=%0d/%0d exp=0/0", exp_q.size(), done_q.size());
    end
  endtask

  task automatic test_dwell0();
    int base_m;
    tick(40);
    write_entry(3'd0, 16'h3000, 16'h0300, 16'd0);
    write_entry(3'd1, 16'h3100, 16'h0310, 16'd0);
    exp_q.push_back('{16'h3000, 16'h0300, 3'd0, -1, -1});
    exp_q.push_back('{16'h3100, 16'h0310, 3'd1, 4, -1});
    done_q.push_back(4);
    base_m = mute_cycles;
    start_seq(4'd2, 1'b0);
    wait_idle(40, "dwell0");
    tick(40);
    checks++;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      errors++; $display("FAIL dwell0_pending got=%0d/%0d exp=0/0", exp_q.size(), done_q.size());
    end
    checks++;
    if (mute_cycles - base_m != (HOLD ? 4 + HO : 0)) begin
      errors++; $display("FAIL mute_length got=%0d exp=%0d", mute_cycles - base_m, HOLD ? 4 + HO : 0);
    end
  endtask

  task automatic test_reset_mid();
    int base_a = applies;
    int base_d;
    exp_q.push_back('{16'h3000, 16'h0300, 3'd0, -1, -1});
    start_seq(4'd2, 1'b1);
    wait_applies(base_a + 1, 20, "reset_mid");
    reset = 1'b1;
    tick();
    checks++;
    if ({complex_phase_inc, real_phase_inc, hop_index} !== 35'h0) begin
      errors++; $display("FAIL midreset_values got=%h/%h/%0d exp=0/0/0", complex_phase_inc,
                         real_phase_inc, hop_index);
    end
    checks++;
    if ({busy, wr_ready, tune_apply, hop_done, cfg_err, rx_mute} !== 6'b010000) begin
      errors++; $display("FAIL midreset_flags got=%b exp=010000",
                         {busy, wr_ready, tune_apply, hop_done, cfg_err, rx_mute});
    end
    reset = 1'b0;
    base_a = applies;
    base_d = dones;
    tick(10);
    checks++;
    if (applies != base_a || dones != base_d) begin
      errors++; $display("FAIL midreset_quiet got=%0d/%0d exp=%0d/%0d", applies, dones, base_a, base_d);
    end
    exp_q.push_back('{16'h0000, 16'h0000, 3'd0, -1, -1});
    done_q.push_back(4);
    start_seq(4'd1, 1'b0);
    wait_idle(40, "table_clear");
    tick();
    checks++;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      errors++; $display("FAIL table_clear_pending got=%0d/%0d exp=0/0", exp_q.size(), done_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_alignment();
    test_loop_stop();
    test_errors();
    test_dwell0();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_tuning_scheduler.md
RX_TUNING_SCHEDULER -- requirements
Module: rx_tuning_scheduler

Interface
REQ-001 Parameter NUMBER_OF_PATH, default 4: polyphase factor; all tuning updates align to this sample-group boundary.
REQ-002 Parameter TABLE_DEPTH, default 8: number of hop-table entries, power of two, 2..64.
REQ-003 Parameter DWELL_WIDTH, default 16: width of each entry's dwell field.
REQ-004 Parameter HOLDOFF_CYCLES, default 32: mute length after each retune; used only under RX_TUNE_HOLDOFF_EN.
REQ-005 clock  input  1  sole clock; every register is rising-edge clocked.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 wr_valid  input  1  table-write request.
REQ-008 wr_ready  output  1  table write accepted when wr_valid and wr_ready are both high.
REQ-009 wr_addr  input  log2(TABLE_DEPTH)  entry index.
REQ-010 wr_cinc  input  16  complex-mixer phase increment for the entry.
REQ-011 wr_rinc  input  16  real-mixer phase increment for the entry.
REQ-012 wr_dwell  input  DWELL_WIDTH  dwell in NUMBER_OF_PATH-cycle groups.
REQ-013 start  input  1  single-cycle pulse; begins a hop sequence.
REQ-014 stop  input  1  single-cycle pulse; aborts a sequence.
REQ-015 loop_en  input  1  sampled at start; repeat the sequence indefinitely.
REQ-016 hop_count  input  log2(TABLE_DEPTH)+1  sampled at start; number of entries used (1..TABLE_DEPTH).
REQ-017 complex_phase_inc  output  16  drives the complex DDS.
REQ-018 real_phase_inc  output  16  drives the real DDS.
REQ-019 tune_apply  output  1  one-cycle pulse in the cycle the phase increments change.
REQ-020 hop_index  output  log2(TABLE_DEPTH)  index of the entry currently applied.
REQ-021 busy  output  1  high in any state other than IDLE.
REQ-022 hop_done  output  1  one-cycle pulse when a non-looping sequence completes.
REQ-023 cfg_err  output  1  one-cycle pulse when start is rejected.
REQ-024 rx_mute  output  1  high while downstream filters settle after a retune.

Function
REQ-025 A free-running path counter SHALL count 0..NUMBER_OF_PATH-1 and wrap; the cycle in which it equals NUMBER_OF_PATH-1 is the boundary cycle.
REQ-026 wr_ready SHALL equal !busy; writes while busy are not accepted and the table is unchanged.
REQ-027 The FSM SHALL have four states: IDLE, LOAD, DWELL and DONE.
REQ-028 IDLE -> LOAD SHALL occur on start when 1 <= hop_count <= TABLE_DEPTH; the index is cleared to 0 and hop_count and loop_en are latched.
REQ-029 A start with hop_count 0 or above TABLE_DEPTH SHALL pulse cfg_err in the next cycle and remain in IDLE.
REQ-030 In LOAD on a boundary cycle, the next cycle SHALL update complex_phase_inc, real_phase_inc and hop_index from the current entry, pulse tune_apply and enter DWELL.
REQ-031 DWELL SHALL last exactly max(dwell,1)*NUMBER_OF_PATH cycles, counted from the tune_apply cycle.
REQ-032 DWELL exit SHALL depend on the index: if index < count-1, increment the index and go to LOAD; if last and loop_en is latched, set the index to 0 and go to LOAD; if last and not looping, go to DONE.
REQ-033 Successive tune_apply pulses SHALL therefore be spaced exactly dwell*NUMBER_OF_PATH cycles apart, with no extra gap cycles.
REQ-034 DONE SHALL pulse hop_done for one cycle and return to IDLE.
REQ-035 On stop in any state, the next state SHALL be IDLE, with no hop_done pulse.
REQ-036 When stop and start arrive together, stop SHALL win.
REQ-037 A start received while busy SHALL be ignored.
REQ-038 Phase-increment outputs SHALL hold their last value in IDLE.
REQ-039 Table reads SHALL be registered; the reset contents of every entry are 0.

Reset
REQ-040 On reset, all outputs SHALL clear to 0, except wr_ready, which is 1.
REQ-041 On reset, the FSM SHALL go to IDLE and the path counter to 0.
REQ-042 On reset, all table entries SHALL clear to 0.
REQ-043 Reset mid-sequence SHALL abort the sequence with no hop_done pulse.

Configuration
REQ-044 Macro RX_TUNE_HOLDOFF_EN SHALL select the rx_mute behaviour.
REQ-045 With RX_TUNE_HOLDOFF_EN defined, rx_mute SHALL assert in the tune_apply cycle and stay high HOLDOFF_CYCLES cycles; a retune during holdoff restarts the count.
REQ-046 Without RX_TUNE_HOLDOFF_EN, rx_mute SHALL be tied to 0 and the holdoff counter SHALL not be implemented.

Verification
REQ-047 Single sequence: write entry0 (cinc 0x1000, rinc 0x0800, dwell 2) and entry1 (0x2000, 0x0400, 3); start with hop_count 2 -> two tune_apply pulses 8 cycles apart, then hop_done 12 cycles after the second, with outputs holding 0x2000/0x0400.
REQ-048 Alignment: start issued at each path-counter phase 0..3 -> tune_apply always follows a boundary cycle, and its phase is identical in all four runs.
REQ-049 Loop and stop: loop_en=1, hop_count 2 -> hop_index sequence 0,1,0,1...; stop mid-DWELL -> busy low the next cycle, no hop_done, outputs hold.
REQ-050 Errors and contention: start with hop_count 0 and with 9 -> cfg_err pulse, busy stays 0; a write attempted while busy is not accepted and the entry is unchanged; start with stop together -> stays IDLE.
REQ-051 Dwell 0 and holdoff: an entry with dwell 0 behaves as dwell 1 (4 cycles); with RX_TUNE_HOLDOFF_EN, rx_mute is high for 32 cycles after each apply.
REQ-052 Reset mid-DWELL: assert reset -> the next cycle shows all outputs 0, wr_ready 1, and the table reads 0.
